mux8_rr_scheduler: RTL and testbench

Round-robin scheduler that shares one 8:1 single-bit mux between eight requesters. It arbitrates the request lines and drives the mux select. It holds each grant until the owner releases it, the owner drops its request, or a hold timeout expires. A one-cycle dead gap separates consecutive grants so the mux never switches while an owner is marked valid.

---
 rtl/mux8_rr_scheduler.sv | 104 ++++++++++
 tb/tb_mux8_rr_scheduler.sv | 136 +++++++++++++
 2 files changed

// File: rtl/mux8_rr_scheduler.sv
// Round-robin scheduler for one shared 8:1 single-bit mux.
// Grants are held until done, request drop or hold timeout, then a one-cycle gap follows.
module mux8_rr_scheduler #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [2:0] sel,
  output logic [7:0] gnt,
  output logic       gnt_valid,
  output logic       timeout
);

  // state | meaning
  // IDLE  | no owner; arbitrate among active requests
  // GRANT | owner sel holds the mux; hold_cnt counts cycles
  // GAP   | one dead cycle after release; sel frozen
  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  state_t           state;
  logic [2:0]       last;
  logic [CNT_W-1:0] hold_cnt;

  logic       found;
  logic [2:0] pick;
  logic [2:0] idx;
  logic       rel_done;
  logic       rel_drop;
  logic       rel_time;
  logic       rel_any;
  logic       time_only;

  // Search starts one past the last owner so a persistent requester yields to the others.
  always_comb begin
    found = 1'b0;
    pick  = 3'd0;
    idx   = 3'd0;
    for (int i = 1; i <= 8; i++) begin
      idx = last + 3'(i);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign rel_done  = done;
  assign rel_drop  = !req[sel];
  assign rel_time  = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
  assign rel_any   = rel_done || rel_drop || rel_time;
  assign time_only = rel_time && !rel_done && !rel_drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last      <= 3'd7;
      hold_cnt  <= '0;
      sel       <= 3'd0;
      gnt       <= 8'd0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          timeout <= 1'b0;
          if (found) begin
            sel       <= pick;
            gnt       <= 8'd1 << pick;
            gnt_valid <= 1'b1;
            hold_cnt  <= '0;
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (rel_any) begin
            gnt       <= 8'd0;
            gnt_valid <= 1'b0;
            last      <= sel;
            timeout   <= time_only;
            state     <= GAP;
          end else begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        GAP: begin
          timeout <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          gnt       <= 8'd0;
          gnt_valid <= 1'b0;
          timeout   <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux8_rr_scheduler.sv
// Directed bench for mux8_rr_scheduler with MAX_HOLD=4.
// Outputs are checked 1 time unit after each rising edge; inputs change at the same point.
module tb_mux8_rr_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic [2:0] sel;
  logic [7:0] gnt;
  logic       gnt_valid;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  mux8_rr_scheduler #(.MAX_HOLD(4), .CNT_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .sel       (sel),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [2:0] e_sel, input logic e_valid,
                     input logic e_to);
    logic [12:0] obs;
    logic [12:0] exp;
    obs = {sel, gnt, gnt_valid, timeout};
    exp = {e_sel, (e_valid ? (8'd1 << e_sel) : 8'd0), e_valid, e_to};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: sel/gnt/valid/timeout observed %0d/%h/%b/%b expected %0d/%h/%b/%b",
             tag, sel, gnt, gnt_valid, timeout, exp[12:10], exp[9:2], exp[1], exp[0]);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 8'h00;
    done  = 1'b0;
    tick();
    tick();
    chk("reset", 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // lone requester 0, done after 3 grant cycles, then re-granted
    req = 8'h01;
    tick(); chk("s1_grant0", 3'd0, 1'b1, 1'b0);
    tick();
    tick(); chk("s1_hold", 3'd0, 1'b1, 1'b0);
    done = 1'b1;
    tick(); chk("s1_release", 3'd0, 1'b0, 1'b0);
    done = 1'b0;
    tick(); chk("s1_gap", 3'd0, 1'b0, 1'b0);
    tick(); chk("s1_regrant0", 3'd0, 1'b1, 1'b0);
    req = 8'h00;
    tick(); chk("s1_drop_release", 3'd0, 1'b0, 1'b0);
    tick();
    tick(); chk("s1_idle", 3'd0, 1'b0, 1'b0);

    // all requesting, done every grant: order 1..7,0,1 (last owner was 0)
    req = 8'hFF;
    for (int k = 1; k <= 9; k++) begin
      tick(); chk($sformatf("s2_grant_%0d", k), 3'(k), 1'b1, 1'b0);
      done = 1'b1;
      tick(); chk($sformatf("s2_rel_%0d", k), 3'(k), 1'b0, 1'b0);
      done = 1'b0;
      if (k == 9) req = 8'h00;
      tick(); chk($sformatf("s2_gap_%0d", k), 3'(k), 1'b0, 1'b0);
    end

    // timeout: req 2 and 5, last owner 1
    req = 8'h24;
    tick(); chk("s3_grant2", 3'd2, 1'b1, 1'b0);
    tick();
    tick();
    tick(); chk("s3_hold4", 3'd2, 1'b1, 1'b0);
    tick(); chk("s3_timeout2", 3'd2, 1'b0, 1'b1);
    tick(); chk("s3_gap_pulse_end", 3'd2, 1'b0, 1'b0);
    tick(); chk("s3_grant5", 3'd5, 1'b1, 1'b0);
    tick();
    tick();
    tick(); chk("s3_hold5", 3'd5, 1'b1, 1'b0);
    tick(); chk("s3_timeout5", 3'd5, 1'b0, 1'b1);
    tick(); chk("s3_gap5", 3'd5, 1'b0, 1'b0);
    tick(); chk("s3_grant2_again", 3'd2, 1'b1, 1'b0);

    // done coinciding with the last hold cycle: no timeout pulse
    tick();
    tick();
    tick(); chk("s4_hold_last", 3'd2, 1'b1, 1'b0);
    done = 1'b1;
    tick(); chk("s4_done_wins", 3'd2, 1'b0, 1'b0);
    tick(); chk("s4_gap", 3'd2, 1'b0, 1'b0);
    done = 1'b0;

    // owner 3 withdraws mid-grant; next grant goes to 7
    req = 8'h88;
    tick(); chk("s5_grant3", 3'd3, 1'b1, 1'b0);
    tick();
    req = 8'h80;
    tick(); chk("s5_drop_release", 3'd3, 1'b0, 1'b0);
    tick();
    tick(); chk("s5_grant7", 3'd7, 1'b1, 1'b0);

    // asynchronous reset between edges while 7 owns the mux
    tick();
    #3 rst_n = 1'b0;
    #1 chk("s6_async_reset", 3'd0, 1'b0, 1'b0);
    tick(); chk("s6_held_reset", 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick(); chk("s6_grant7", 3'd7, 1'b1, 1'b0);
    done = 1'b1;
    tick(); chk("s6_release7", 3'd7, 1'b0, 1'b0);
    done = 1'b0;
    req  = 8'h81;
    tick();
    tick(); chk("s6_wrap_to0", 3'd0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
